map_access_arbiter: RTL and testbench

Shares the single-port map-wall ROM between the player and boss movement engines of the game datapath. Each engine requests a one-pixel move in a direction. The arbiter computes the candidate position, reads the two sprite-corner wall bits, and returns an accept/reject with the resulting position. Round-robin arbitration keeps the boss chaser from starving the keyboard-driven player, and vice versa.

---
 rtl/map_access_arbiter.sv | 126 ++++++++++++
 tb/tb_map_access_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/map_access_arbiter.sv
// map_access_arbiter: round-robin arbiter sharing the map-wall ROM between the player and boss movers (optional `MAP_OOB_CHECK_EN bounds check).
module map_access_arbiter #(
  parameter int ORG_X = 60,
  parameter int ORG_Y = 30,
  parameter int CELL  = 5,
  parameter int SPAN  = 10,
  parameter int MAP_W = 40,
  parameter int MAP_H = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_req,
  input  logic [1:0] p_dir,
  input  logic [8:0] p_x,
  input  logic [8:0] p_y,
  input  logic       b_req,
  input  logic [1:0] b_dir,
  input  logic [8:0] b_x,
  input  logic [8:0] b_y,
  output logic [5:0] map_row,
  output logic [5:0] map_col,
  input  logic       map_bit,
  output logic       p_done,
  output logic       b_done,
  output logic       mv_ok,
  output logic [8:0] new_x,
  output logic [8:0] new_y,
  output logic       busy
);
`ifdef MAP_OOB_CHECK_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RESP} state_t;
  state_t state, nxt;
  logic ptr, sel, w0, grant_b, oob;
  logic [1:0] sdir;
  logic [8:0] sx, sy, nx, ny, cur_x, cur_y, cx, cy, dx, dy, dx1, dy1;
  logic [5:0] row_q, col_q, row0, col0, row1, col1;
  assign grant_b = b_req & (~p_req | ptr);
  assign sx = grant_b ? b_x : p_x;
  assign sy = grant_b ? b_y : p_y;
  assign sdir = grant_b ? b_dir : p_dir;
  assign nx = sdir == 2'd1 ? sx - 9'd1 : sdir == 2'd3 ? sx + 9'd1 : sx;
  assign ny = sdir == 2'd0 ? sy - 9'd1 : sdir == 2'd2 ? sy + 9'd1 : sy;
  assign dx = cx - 9'(ORG_X);
  assign dy = cy - 9'(ORG_Y);
  assign dx1 = dx + 9'(SPAN);
  assign dy1 = dy + 9'(SPAN);
  assign row0 = 6'(dy / 9'(CELL));
  assign col0 = 6'(dx / 9'(CELL));
  assign row1 = 6'(dy1 / 9'(CELL));
  assign col1 = 6'(dx1 / 9'(CELL));
  // widened to 10 bits so the far-edge test does not wrap near x/y = 511
  assign oob = OOB_EN & (({1'b0, cx} < 10'(ORG_X)) | ({1'b0, cy} < 10'(ORG_Y)) |
               ({1'b0, cx} + 10'(SPAN) >= 10'(ORG_X + CELL * MAP_W)) |
               ({1'b0, cy} + 10'(SPAN) >= 10'(ORG_Y + CELL * MAP_H)));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = (p_req | b_req) ? RD0 : IDLE;
      RD0:  nxt = oob ? RESP : RD1;
      RD1:  nxt = RD2;
      RD2:  nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    p_done = state == RESP & ~sel;
    b_done = state == RESP & sel;
    map_row = state == RD0 ? row0 : state == RD1 ? row1 : row_q;
    map_col = state == RD0 ? col0 : state == RD1 ? col1 : col_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
      sel <= 1'b0;
      w0 <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      cx <= '0;
      cy <= '0;
      row_q <= '0;
      col_q <= '0;
      mv_ok <= 1'b0;
      new_x <= '0;
      new_y <= '0;
    end else begin
      case (state)
        IDLE: if (p_req | b_req) begin
          sel <= grant_b;
          cur_x <= sx;
          cur_y <= sy;
          cx <= nx;
          cy <= ny;
        end
        RD0: begin
          row_q <= row0;
          col_q <= col0;
          if (oob) begin
            mv_ok <= 1'b0;
            new_x <= cur_x;
            new_y <= cur_y;
          end
        end
        RD1: begin
          row_q <= row1;
          col_q <= col1;
          w0 <= map_bit;
        end
        RD2: begin
          mv_ok <= ~(w0 | map_bit);
          new_x <= (w0 | map_bit) ? cur_x : cx;
          new_y <= (w0 | map_bit) ? cur_y : cy;
        end
        RESP: ptr <= ~sel;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_map_access_arbiter.sv
// tb_map_access_arbiter: directed spec cases plus randomized traffic checked against a transaction-level model.
module tb_map_access_arbiter;
  localparam int ORG_X = 60, ORG_Y = 30, CELL = 5, SPAN = 10, MAP_W = 40, MAP_H = 40;
  logic clk = 0, rst = 1;
  logic p_req = 0, b_req = 0;
  logic [1:0] p_dir = 0, b_dir = 0;
  logic [8:0] p_x = 0, p_y = 0, b_x = 0, b_y = 0;
  logic [5:0] map_row, map_col;
  logic map_bit = 0;
  logic p_done, b_done, mv_ok, busy;
  logic [8:0] new_x, new_y;
  logic rom [64][64];
  int errors = 0, checks = 0;
  int lat, pc1, pc2, bc1, both;
  logic done_b, ok;
  logic [8:0] nx, ny;
  logic [5:0] rows [1:2], cols [1:2];

  map_access_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_dir(p_dir), .p_x(p_x), .p_y(p_y),
    .b_req(b_req), .b_dir(b_dir), .b_x(b_x), .b_y(b_y),
    .map_row(map_row), .map_col(map_col), .map_bit(map_bit),
    .p_done(p_done), .b_done(b_done), .mv_ok(mv_ok),
    .new_x(new_x), .new_y(new_y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) map_bit <= rom[map_row][map_col];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {30'd0, map_row, map_col, p_done, b_done, mv_ok, new_x, new_y, busy};
  endfunction

  task automatic rom_clear();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) rom[r][c] = (r >= MAP_H) || (c >= MAP_W);
  endtask

  task automatic move(input logic boss, input logic [1:0] dir, input logic [8:0] x, input logic [8:0] y);
    @(negedge clk);
    if (boss) begin b_dir = dir; b_x = x; b_y = y; b_req = 1; end
    else begin p_dir = dir; p_x = x; p_y = y; p_req = 1; end
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k <= 2) begin rows[k] = map_row; cols[k] = map_col; end
      if (p_done | b_done) begin
        lat = k; done_b = b_done; ok = mv_ok; nx = new_x; ny = new_y;
        p_req = 0; b_req = 0;
      end
    end
    p_req = 0; b_req = 0;
  endtask

  // Outcome of one move decided directly from the map geometry.
  function automatic void predict(input logic [8:0] x, input logic [8:0] y, input logic [1:0] d,
                                  output int l, output logic o, output logic [8:0] ox, output logic [8:0] oy);
    int cx, cy, r0, c0, r1, c1;
    cx = (int'(x) + (d == 2'd3 ? 1 : d == 2'd1 ? -1 : 0) + 512) % 512;
    cy = (int'(y) + (d == 2'd2 ? 1 : d == 2'd0 ? -1 : 0) + 512) % 512;
    r0 = ((cy - ORG_Y + 512) % 512) / CELL % 64;
    c0 = ((cx - ORG_X + 512) % 512) / CELL % 64;
    r1 = ((cy - ORG_Y + SPAN + 512) % 512) / CELL % 64;
    c1 = ((cx - ORG_X + SPAN + 512) % 512) / CELL % 64;
    l = 4; o = !(rom[r0][c0] || rom[r1][c1]);
`ifdef MAP_OOB_CHECK_EN
    if (cx < ORG_X || cy < ORG_Y || cx + SPAN >= ORG_X + CELL * MAP_W || cy + SPAN >= ORG_Y + CELL * MAP_H) begin
      l = 2; o = 0;
    end
`endif
    ox = o ? 9'(cx) : x;
    oy = o ? 9'(cy) : y;
  endfunction

  initial begin
    int m_left, m_lat;
    logic m_ptr, m_sel, m_ok;
    logic [8:0] m_nx, m_ny;
    rom_clear();
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    rst = 0;
    @(negedge clk);
    chk("idle_outs", outs(), 0);

    move(1, 2'd2, 9'd100, 9'd100);
    chk("boss_lat", lat, 4); chk("boss_who", done_b, 1);
    chk("boss_ok", ok, 1); chk("boss_xy", {nx, ny}, {9'd100, 9'd101});

    move(0, 2'd3, 9'd65, 9'd125);
    chk("free_lat", lat, 4); chk("free_who", done_b, 0); chk("free_ok", ok, 1);
    chk("free_xy", {nx, ny}, {9'd66, 9'd125});
    chk("free_adr0", {rows[1], cols[1]}, {6'd19, 6'd1});
    chk("free_adr1", {rows[2], cols[2]}, {6'd21, 6'd3});

    rom[21][3] = 1;
    move(0, 2'd3, 9'd65, 9'd125);
    chk("wall_lat", lat, 4); chk("wall_ok", ok, 0);
    chk("wall_xy", {nx, ny}, {9'd65, 9'd125});
    rom[21][3] = 0;

    move(0, 2'd1, 9'd60, 9'd100);
`ifdef MAP_OOB_CHECK_EN
    chk("oob_lat", lat, 2); chk("oob_ok", ok, 0); chk("oob_xy", {nx, ny}, {9'd60, 9'd100});
`else
    chk("oob_lat", lat, 4); chk("oob_ok", ok, 1); chk("oob_xy", {nx, ny}, {9'd59, 9'd100});
`endif

    @(negedge clk);
    p_x = 65; p_y = 125; p_dir = 3; p_req = 1;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1; b_req = 1; b_x = 100; b_y = 100; b_dir = 0;
    @(negedge clk);
    chk("mid_rst_outs", outs(), 0);
    rst = 0;
    pc1 = 0; pc2 = 0; bc1 = 0; both = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (p_done && b_done) both++;
      if (p_done) begin if (pc1 == 0) pc1 = k; else if (pc2 == 0) pc2 = k; end
      if (b_done && bc1 == 0) bc1 = k;
    end
    chk("cont_p1", pc1, 4); chk("cont_b1", bc1, 9); chk("cont_p2", pc2, 14); chk("cont_overlap", both, 0);

    rst = 1; p_req = 0; b_req = 0;
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < MAP_H; r++)
      for (int c = 0; c < MAP_W; c++) rom[r][c] = ($urandom_range(0, 99) < 15);
    p_x = 120; p_y = 120; b_x = 200; b_y = 180;
    m_left = 0; m_ptr = 0; m_sel = 0; m_ok = 0; m_nx = 0; m_ny = 0; m_lat = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!p_req && $urandom_range(0, 2) == 0) begin
        p_req = 1; p_dir = 2'($urandom);
        if ($urandom_range(0, 19) == 0) begin p_x = 9'($urandom_range(55, 255)); p_y = 9'($urandom_range(25, 225)); end
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_dir = 2'($urandom);
        if ($urandom_range(0, 19) == 0) begin b_x = 9'($urandom_range(55, 255)); b_y = 9'($urandom_range(25, 225)); end
      end
      if ($urandom_range(0, 9) == 0) p_dir = 2'($urandom);
      if ($urandom_range(0, 9) == 0) b_dir = 2'($urandom);
      if (m_left == 0 && (p_req || b_req)) begin
        m_sel = b_req && (!p_req || m_ptr);
        if (m_sel) predict(b_x, b_y, b_dir, m_lat, m_ok, m_nx, m_ny);
        else predict(p_x, p_y, p_dir, m_lat, m_ok, m_nx, m_ny);
        m_ptr = !m_sel;
        m_left = m_lat + 1;
      end
      @(negedge clk);
      if (m_left > 0) m_left--;
      chk("rnd_busy", busy, m_left != 0);
      chk("rnd_p_done", p_done, m_left == 1 && !m_sel);
      chk("rnd_b_done", b_done, m_left == 1 && m_sel);
      if (m_left == 1) begin
        chk("rnd_ok", mv_ok, m_ok);
        chk("rnd_xy", {new_x, new_y}, {m_nx, m_ny});
        if (m_sel) begin b_x = m_nx; b_y = m_ny; b_req = $urandom_range(0, 1); end
        else begin p_x = m_nx; p_y = m_ny; p_req = $urandom_range(0, 1); end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
